// File: rtl/pong_pkg.sv
// Shared definitions for the pong front-end.
// Holds button index constants, the channel count, the debounce interval
// for synthesis and for simulation, and a helper for the idle raw level.
package pong_pkg;

    localparam int NUM_BUTTONS    = 4;

    localparam int BTN_UP_LEFT    = 0;
    localparam int BTN_DOWN_LEFT  = 1;
    localparam int BTN_UP_RIGHT   = 2;
    localparam int BTN_DOWN_RIGHT = 3;

    // 250000 cycles is 10 ms at 25 MHz; the short value keeps benches fast.
    localparam int DEBOUNCE_CYCLES_SYN = 250000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    // Raw pin level of a button that is not pressed.
    function automatic logic released_raw(input int active_low);
        logic idle;
        if (active_low != 0) begin
            idle = 1'b1;
        end else begin
            idle = 1'b0;
        end
        return idle;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit button channel: two-flop synchroniser, polarity normalisation,
// stable-interval debounce counter, debounced level and one-cycle pulses.
// Ports:
//   clk       - single clock domain
//   rst_n     - asynchronous active-low reset
//   raw       - asynchronous raw button pin
//   level     - debounced level, 1 = pressed
//   press     - one-cycle pulse when a press is accepted
//   release_p - one-cycle pulse when a release is accepted
module debounce_channel
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_p
);

    localparam logic             RAW_IDLE = released_raw(ACTIVE_LOW);
    localparam logic             POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q,   rel_d;
    logic             s_pressed;

    // Next-state logic: synchroniser shift, debounce counting and pulses.
    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        s_pressed = sync2_q ^ POL;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        if (s_pressed == level_q) begin
            // Any return to the accepted level restarts the full interval.
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            level_d = s_pressed;
            cnt_d   = {CNT_W{1'b0}};
            press_d = s_pressed;
            rel_d   = ~s_pressed;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; sync stages reset to the idle raw level so no edge is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level     = level_q;
    assign press     = press_q;
    assign release_p = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Paddle button front-end for the pong core.
// Debounces each raw button and adds a per-frame capture so that taps
// shorter than a frame are still seen by a core that samples once per frame.
// Ports:
//   clock_25M   - pixel clock, single domain
//   reset_n     - asynchronous active-low reset
//   btn_raw     - raw button pins
//   frame       - one-cycle strobe at start of vertical blanking
//   btn_level   - debounced level, 1 = pressed
//   btn_press   - one-cycle accepted-press pulses
//   btn_release - one-cycle accepted-release pulses
//   btn_frame   - per-frame command, updated only on frame
module button_conditioner
    import pong_pkg::*;
#(
    parameter int NUM_BUTTONS     = pong_pkg::NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                   clock_25M,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    input  logic                   frame,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_frame
);

    logic [NUM_BUTTONS-1:0] sticky_q,    sticky_d;
    logic [NUM_BUTTONS-1:0] btn_frame_q, btn_frame_d;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk       (clock_25M),
            .rst_n     (reset_n),
            .raw       (btn_raw[i]),
            .level     (btn_level[i]),
            .press     (btn_press[i]),
            .release_p (btn_release[i])
        );
    end

    // Frame capture: presses accumulate between strobes; a press pulse that
    // lands on the strobe goes into this capture rather than the next sticky.
    always_comb begin
        sticky_d    = sticky_q;
        btn_frame_d = btn_frame_q;
        if (frame) begin
            btn_frame_d = btn_level | sticky_q | btn_press;
            sticky_d    = {NUM_BUTTONS{1'b0}};
        end else begin
            sticky_d    = sticky_q | btn_press;
        end
    end

    // Frame capture registers.
    always_ff @(posedge clock_25M or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q    <= {NUM_BUTTONS{1'b0}};
            btn_frame_q <= {NUM_BUTTONS{1'b0}};
        end else begin
            sticky_q    <= sticky_d;
            btn_frame_q <= btn_frame_d;
        end
    end

    assign btn_frame = btn_frame_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce interval
// and active-low raw inputs. A vector table covers reset release, clean
// press/release and bounce rejection; hand sequences cover frame capture
// and asynchronous reset in the middle of a count.
module tb_button_conditioner;

    logic       clock_25M;
    logic       reset_n;
    logic [3:0] btn_raw;
    logic       frame;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_frame;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] raw;
        logic       frm;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] bfr;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1)
    ) dut (
        .clock_25M   (clock_25M),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .frame       (frame),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_frame   (btn_frame)
    );

    initial clock_25M = 1'b0;
    always #5 clock_25M = ~clock_25M;

    task automatic tick();
        @(posedge clock_25M);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                             input logic [3:0] rel, input logic [3:0] bfr);
        check({tag, ".level"},   btn_level,   lvl);
        check({tag, ".press"},   btn_press,   prs);
        check({tag, ".release"}, btn_release, rel);
        check({tag, ".frame"},   btn_frame,   bfr);
    endtask

    task automatic add(input logic [3:0] raw, input logic frm, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rel, input logic [3:0] bfr);
        vec_t v;
        v.raw = raw; v.frm = frm; v.lvl = lvl; v.prs = prs; v.rel = rel; v.bfr = bfr;
        vecs.push_back(v);
    endtask

    // Pulse frame for exactly one sampled edge.
    task automatic frame_pulse();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        btn_raw = 4'b0000;
        frame   = 1'b0;

        // Table: each row's inputs are sampled by one edge; expectations follow it.
        // Reset release with all buttons held: accepted on the 6th edge.
        for (int k = 0; k < 5; k++) add(4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        add(4'b0000, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        // Release all.
        for (int k = 0; k < 5; k++) add(4'b1111, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        add(4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Clean press on ch0.
        for (int k = 0; k < 5; k++) add(4'b1110, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1110, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(4'b1110, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        // Bounce on ch1, settles pressed from the 5th row; accepted on the 10th.
        add(4'b1100, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1110, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1100, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1110, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) add(4'b1100, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1100, 1'b0, 4'b0011, 4'b0010, 4'b0000, 4'b0000);
        add(4'b1100, 1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        // Frames: first capture includes every press since reset, then it holds,
        // then the next capture shows only the held level.
        add(4'b1100, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b1111);
        add(4'b1100, 1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b1111);
        add(4'b1100, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0011);

        // Reset state.
        ticks(3);
        check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw = vecs[i].raw;
            frame   = vecs[i].frm;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].bfr);
        end
        frame = 1'b0;

        // Short tap on ch2 between frames.
        btn_raw = 4'b1000;
        ticks(5);
        tick();
        check_all("tap.accept", 4'b0111, 4'b0100, 4'b0000, 4'b0011);
        ticks(4);
        btn_raw = 4'b1100;
        ticks(5);
        check("tap.still_high", btn_level, 4'b0111);
        tick();
        check_all("tap.drop", 4'b0011, 4'b0000, 4'b0100, 4'b0011);
        ticks(3);
        frame_pulse();
        check("tap.frame1", btn_frame, 4'b0111);
        ticks(10);
        check("tap.hold", btn_frame, 4'b0111);
        frame_pulse();
        check("tap.frame2", btn_frame, 4'b0011);

        // Press on ch3 coinciding with frame, held across a later frame.
        btn_raw = 4'b0100;
        ticks(5);
        tick();
        check_all("coin.accept", 4'b1011, 4'b1000, 4'b0000, 4'b0011);
        frame_pulse();
        check("coin.frame", btn_frame, 4'b1011);
        ticks(49);
        frame_pulse();
        check("coin.held", btn_frame, 4'b1011);
        btn_raw = 4'b1100;
        ticks(5);
        tick();
        check_all("coin.release", 4'b0011, 4'b0000, 4'b1000, 4'b1011);
        frame_pulse();
        check("coin.after_rel", btn_frame, 4'b0011);

        // Press pulse on a frame must not leak into the following capture.
        btn_raw = 4'b0100;
        ticks(6);
        frame_pulse();
        check("leak.frame", btn_frame, 4'b1011);
        btn_raw = 4'b1100;
        ticks(6);
        check("leak.level", btn_level, 4'b0011);
        frame_pulse();
        check("leak.next", btn_frame, 4'b0011);

        // Asynchronous reset while ch0 release is part-way through its count.
        btn_raw = 4'b1101;
        ticks(4);
        check("areset.before", btn_level, 4'b0011);
        reset_n = 1'b0;
        #2;
        check_all("areset.now", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        ticks(2);
        check_all("areset.held", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b1;
        ticks(5);
        check_all("areset.wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check_all("areset.reaccept", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        tick();
        check_all("areset.settled", 4'b0010, 4'b0000, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
